// File: rtl/midi_pkg.sv
// Shared types, constants and status-byte helpers for the MIDI input receiver.
package midi_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int unsigned MIDI_BAUD_CNT = 3200;
  localparam logic [7:0]  ST_SYSEX_LO   = 8'hF0;
  localparam logic [7:0]  ST_RT_LO      = 8'hF8;

  // Data bytes carried by a channel-voice status; 0 for non-channel bytes.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd2;
    if (!status[7] || status >= ST_SYSEX_LO) begin
      len = 2'd0;
    end else if (status[7:5] == 3'b110) begin
      len = 2'd1;
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial byte receiver: input synchroniser, start-edge detect, mid-bit sampling.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned BAUD_CNT = MIDI_BAUD_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(BAUD_CNT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_CNT - 1);

  rx_state_t        state_q;
  logic [1:0]       sync_q;
  logic [1:0]       sync_vld_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             rx_s;
  logic             stop_hit;

  assign rx_s = sync_q[1];

  // sync_vld_q masks the reset-preset synchroniser stages so a line held low
  // across reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      sync_vld_q <= 2'b00;
      prev_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      sync_q     <= {sync_q[0], midi_rx};
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      prev_q     <= rx_s & sync_vld_q[1];
      cnt_q      <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          if (prev_q && !rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are decoded in the stop-sample cycle; the parser registers them.
  assign stop_hit   = (state_q == STOP) && (cnt_q == FULL_M1);
  assign byte_valid = stop_hit && rx_s;
  assign frame_err  = stop_hit && !rx_s;
  assign byte_data  = shift_q;

endmodule

// File: rtl/midi_in.sv
// MIDI IN port: byte receiver plus running-status message parser with held outputs.
module midi_in
  import midi_pkg::*;
#(
  parameter int unsigned BAUD_CNT = MIDI_BAUD_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       frame_err
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic [7:0] run_q;
  logic [1:0] need_q;
  logic [7:0] d1_q;
  logic [1:0] byte_len;
  logic [1:0] run_len;

  midi_uart_rx #(.BAUD_CNT(BAUD_CNT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .midi_rx    (midi_rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_ferr)
  );

  assign byte_len = midi_data_len(rx_data);
  assign run_len  = midi_data_len(run_q);

  // Classify each accepted byte; real-time bytes bypass running-status state.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= '0;
      need_q     <= '0;
      d1_q       <= '0;
      msg_valid  <= 1'b0;
      msg_status <= '0;
      msg_data1  <= '0;
      msg_data2  <= '0;
      msg_len    <= '0;
      frame_err  <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      frame_err <= rx_ferr;
      if (rx_valid) begin
        if (rx_data >= ST_RT_LO) begin
          msg_valid  <= 1'b1;
          msg_status <= rx_data;
          msg_data1  <= '0;
          msg_data2  <= '0;
          msg_len    <= 2'd1;
        end else if (rx_data >= ST_SYSEX_LO) begin
          run_q  <= '0;
          need_q <= '0;
        end else if (rx_data[7]) begin
          run_q  <= rx_data;
          need_q <= byte_len;
        end else if (run_q != 8'h00 && need_q != 2'd0) begin
          if (need_q == 2'd1) begin
            msg_valid  <= 1'b1;
            msg_status <= run_q;
            msg_len    <= 2'(run_len + 2'd1);
            need_q     <= run_len;
            if (run_len == 2'd2) begin
              msg_data1 <= d1_q;
              msg_data2 <= rx_data;
            end else begin
              msg_data1 <= rx_data;
              msg_data2 <= '0;
            end
          end else begin
            d1_q   <= rx_data;
            need_q <= 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_in.sv
// Randomised and directed bench for midi_in against a message-level reference model.
module tb_midi_in;

  localparam int BAUD = 16;
  // Line edge -> 2 sync cycles -> stop sample -> registered strobe.
  localparam int LAT  = 2 + BAUD / 2 + 9 * BAUD + 1;

  typedef struct {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
    int         cyc;
  } msg_t;

  logic       clk;
  logic       rst;
  logic       midi_rx;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;
  logic [1:0] msg_len;
  logic       frame_err;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  msg_t exp_msg[$];
  msg_t obs_msg[$];
  int   exp_fe[$];
  int   obs_fe[$];
  msg_t last_exp;
  logic [7:0] run;
  logic [7:0] dq[$];

  midi_in #(.BAUD_CNT(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .midi_rx    (midi_rx),
    .msg_valid  (msg_valid),
    .msg_status (msg_status),
    .msg_data1  (msg_data1),
    .msg_data2  (msg_data2),
    .msg_len    (msg_len),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    msg_t o;
    if (msg_valid) begin
      o.st = msg_status; o.d1 = msg_data1; o.d2 = msg_data2; o.len = msg_len; o.cyc = cyc;
      obs_msg.push_back(o);
    end
    if (frame_err) obs_fe.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    run = 8'h00;
    dq.delete();
    last_exp.st = 8'h00; last_exp.d1 = 8'h00; last_exp.d2 = 8'h00;
    last_exp.len = 2'd0; last_exp.cyc = 0;
  endtask

  task automatic push_msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                          input int len, input int at);
    msg_t m;
    m.st = st; m.d1 = d1; m.d2 = d2; m.len = 2'(len); m.cyc = at;
    exp_msg.push_back(m);
    last_exp = m;
  endtask

  // Message-level MIDI rules: running status, real-time passthrough, SysEx drop.
  task automatic model_byte(input logic [7:0] b, input int start);
    int need;
    if (b >= 8'hF8) begin
      push_msg(b, 8'h00, 8'h00, 1, start + LAT);
    end else if (b >= 8'hF0) begin
      run = 8'h00;
      dq.delete();
    end else if (b[7]) begin
      run = b;
      dq.delete();
    end else if (run != 8'h00) begin
      dq.push_back(b);
      need = (run >= 8'hC0 && run < 8'hE0) ? 1 : 2;
      if (dq.size() == need) begin
        push_msg(run, dq[0], (need == 2) ? dq[1] : 8'h00, need + 1, start + LAT);
        dq.delete();
      end
    end
  endtask

  task automatic bit_time(input logic v);
    midi_rx = v;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    midi_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    int start;
    start = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_b);
    if (stop_b) begin
      model_byte(b, start);
    end else begin
      exp_fe.push_back(start + LAT);
      bit_time(1'b1);
    end
    midi_rx = 1'b1;
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_frame(bytes[i], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string tag);
    int n;
    idle(4);
    chk({tag, ":msg_count"}, 32'(obs_msg.size()), 32'(exp_msg.size()));
    n = (obs_msg.size() < exp_msg.size()) ? obs_msg.size() : exp_msg.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ":status"}, 32'(obs_msg[i].st), 32'(exp_msg[i].st));
      chk({tag, ":data1"},  32'(obs_msg[i].d1), 32'(exp_msg[i].d1));
      chk({tag, ":data2"},  32'(obs_msg[i].d2), 32'(exp_msg[i].d2));
      chk({tag, ":len"},    32'(obs_msg[i].len), 32'(exp_msg[i].len));
      chk({tag, ":msg_cycle"}, 32'(obs_msg[i].cyc), 32'(exp_msg[i].cyc));
    end
    chk({tag, ":ferr_count"}, 32'(obs_fe.size()), 32'(exp_fe.size()));
    n = (obs_fe.size() < exp_fe.size()) ? obs_fe.size() : exp_fe.size();
    for (int i = 0; i < n; i++) chk({tag, ":ferr_cycle"}, 32'(obs_fe[i]), 32'(exp_fe[i]));
    chk({tag, ":hold_status"}, 32'(msg_status), 32'(last_exp.st));
    chk({tag, ":hold_data1"},  32'(msg_data1),  32'(last_exp.d1));
    chk({tag, ":hold_data2"},  32'(msg_data2),  32'(last_exp.d2));
    chk({tag, ":hold_len"},    32'(msg_len),    32'(last_exp.len));
    exp_msg.delete(); obs_msg.delete();
    exp_fe.delete();  obs_fe.delete();
  endtask

  initial begin
    logic [7:0] b;
    int r;
    midi_rx = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset:valid",  32'(msg_valid),  32'd0);
    chk("reset:status", 32'(msg_status), 32'd0);
    chk("reset:data1",  32'(msg_data1),  32'd0);
    chk("reset:data2",  32'(msg_data2),  32'd0);
    chk("reset:len",    32'(msg_len),    32'd0);
    chk("reset:ferr",   32'(frame_err),  32'd0);
    idle(20);

    send_bytes('{8'h90, 8'h3C, 8'h64});
    drain("note_on");
    send_bytes('{8'h3E, 8'h00, 8'hC5, 8'h07});
    drain("running");
    send_bytes('{8'h80, 8'h40, 8'hF8, 8'h10});
    drain("realtime");

    send_frame(8'h55, 1'b0);
    idle(20);
    midi_rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(40);
    send_frame(8'hFE, 1'b1);
    drain("ferr_glitch");

    send_bytes('{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h11});
    drain("sysex");

    send_bytes('{8'h90, 8'h3C});
    do_reset();
    send_bytes('{8'h40, 8'h41});
    drain("rst_mid");

    midi_rx = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (200) @(posedge clk);
    #1;
    idle(40);
    drain("low_rst");

    for (int blk = 0; blk < 6; blk++) begin
      for (int k = 0; k < 10; k++) begin
        r = $urandom_range(0, 9);
        if (r < 2)       b = 8'($urandom_range(8'h80, 8'hEF));
        else if (r < 7)  b = 8'($urandom_range(8'h00, 8'h7F));
        else if (r == 7) b = 8'($urandom_range(8'hF8, 8'hFF));
        else             b = 8'($urandom_range(8'hF0, 8'hF7));
        if (r == 9 && $urandom_range(0, 1) == 1) send_frame(8'($urandom_range(0, 255)), 1'b0);
        else send_frame(b, 1'b1);
        idle($urandom_range(0, 30));
      end
      drain("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_in.md
# midi_in

MIDI input receiver: deserialises the 31.25 kbaud MIDI serial line and assembles complete channel-voice and real-time messages. It is the consuming stage for the serial stream driven by the MIDI transmit controller, so it can be used for loopback checks or a MIDI IN port. Output is one status byte and up to two data bytes, with a single-cycle valid strobe.

## Interface
- `BAUD_CNT`, default 3200: clock ticks per bit (100 MHz / 31250 baud); must be even, ≥ 8.
- `clk` in 1: system clock; every flop is on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `midi_rx` in 1: asynchronous serial line.
  - Idle high; start bit 0; 8 data bits LSB first; stop bit 1.
- `msg_valid` out 1: one-cycle strobe; message fields are valid in this cycle.
- `msg_status` out 8: status byte of the message.
- `msg_data1` out 8: first data byte; 0 when unused.
- `msg_data2` out 8: second data byte; 0 when unused.
- `msg_len` out 2: total bytes in the message, 1..3.
- `frame_err` out 1: one-cycle strobe; stop bit sampled as 0.

## Operation
- **Input sync:** `midi_rx` passes through a 2-flop synchroniser; all logic uses the synchronised value `rx_s`.
- **Byte receiver FSM:** states IDLE, START, DATA, STOP; one tick counter and one 3-bit bit index.
- **IDLE:** a falling edge of `rx_s` (previous 1, current 0) goes to START and clears the counter.
  - The previous-sample flop resets to 0, so a line held low at reset release is never taken as a start bit.
- **START:** at count `BAUD_CNT/2-1`, sample `rx_s`.
  - 0: go to DATA.
  - 1: glitch; return to IDLE with no output.
- **DATA:** sample every `BAUD_CNT` ticks and shift in LSB first; after bit 7 go to STOP.
- **STOP:** sample after `BAUD_CNT` ticks.
  - 1: byte accepted.
  - 0: pulse `frame_err`, discard the byte, return to IDLE. The edge detector then needs `rx_s` high before the next start.
- **Parser state:** `run_status` (8 bits, 0 = none), `need` (data bytes still expected), `d1`.
- Each accepted byte is classified as follows:
  - **0xF8–0xFF (real-time):** emit immediately: status = byte, `msg_len`=1, data = 0. `run_status`, `need` and `d1` are untouched.
  - **0xF0–0xF7 (system common / SysEx):** clear `run_status` and `need`; all data bytes are dropped until the next status byte.
  - **0x80–0xEF (channel voice):** `run_status` = byte. `need` = 1 for 0xC0–0xDF, otherwise 2.
  - **Data byte (bit 7 = 0) with `run_status` = 0:** dropped.
  - **Data byte with `run_status` ≠ 0:** stored into `d1` or `d2`. When the last expected byte arrives, emit status = `run_status`, `msg_len` = 1+count, unused data = 0. Then reload `need` for running status.
- **Holding behaviour:** the `msg_*` fields keep their values after the strobe until the next emit.
  - No backpressure: the consumer must take the message in the strobe cycle.
- **Simultaneity:** only one byte completes per 10-bit frame, so emit and frame-error events never coincide.

## Timing
- **Reset:** every output is 0. The FSM is in IDLE, `run_status` = 0, `need` = 0, and the synchroniser flops are 1.
- **Reset mid-frame or mid-message:** the partial byte and the partial message are discarded and running status is lost.
- **Sampling points:** let t = the cycle in which `rx_s` first reads 0.
  - Start sample at t + `BAUD_CNT/2`.
  - Bit k sample at t + `BAUD_CNT/2` + (k+1)·`BAUD_CNT`.
  - Stop sample at t + `BAUD_CNT/2` + 9·`BAUD_CNT`.
- **Latency:**
  - `msg_valid` or `frame_err` is asserted in the cycle after the stop sample.
  - End-to-end from the line edge is 2 sync cycles plus the above.
- **Back-to-back frames:** a new start bit may begin immediately after the stop sample. The edge detector re-arms once `rx_s` = 1 is seen in STOP.

## Structure
- **Package `midi_pkg`:**
  - `rx_state_t` enum (IDLE, START, DATA, STOP).
  - Constants `MIDI_BAUD_CNT` = 3200, `ST_SYSEX_LO` = 0xF0, `ST_RT_LO` = 0xF8.
  - Function `midi_data_len(status)` returning 0, 1 or 2.
- **Sub-module `midi_uart_rx`:** synchroniser + byte FSM. Outputs `byte_valid` (1-cycle strobe), `byte_data` [7:0], `frame_err`.
- **`midi_in`:** instantiates `midi_uart_rx` and contains the parser and output registers.

## Test plan
All scenarios run with `BAUD_CNT` = 16 and ideal frames unless stated.
- Bytes 0x90 0x3C 0x64 → one `msg_valid`: 0x90/0x3C/0x64, `msg_len` 3. Strobe lands one cycle after the third stop sample.
- Continue with 0x3E 0x00 (running status) → 0x90/0x3E/0x00, len 3. Then 0xC5 0x07 → 0xC5/0x07/0x00, len 2.
- 0x80 0x40 0xF8 0x10 → first 0xF8/0x00/0x00 len 1, then 0x80/0x40/0x10 len 3.
- Frame 0x55 with stop bit 0 → `frame_err` pulse, no `msg_valid`. A low glitch of 5 cycles → no output, FSM back in IDLE.
- 0xF0 0x01 0x02 0xF7 0x11 → no `msg_valid`; the data following SysEx is dropped.
- 0x90 0x3C, then `rst` for 2 cycles, then 0x40 0x41 → no `msg_valid`, outputs 0. Holding `midi_rx` low across reset release → no start detected.
